// File: rtl/bcd_xs3_seq_converter.sv
// Multi-digit BCD <-> Excess-3 converter: accepts a packed word, converts one
// digit per clock (LSD first), then holds the result until the consumer takes it.
module bcd_xs3_seq_converter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   dout,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  din_q, din_d;
    logic                 mode_q, mode_d;
    logic [4*DIGITS-1:0]  dout_q, dout_d;
    logic [DIGITS-1:0]    err_q, err_d;

    logic [3:0]           cur_nib;
    logic [4:0]           conv_res;

    // Returns {illegal, nibble}; an illegal code maps to 4'hF with the flag set.
    function automatic logic [4:0] conv_digit(input logic [3:0] nib, input logic m);
        logic [4:0] res;
        res = {1'b1, 4'hF};
        if (!m) begin
            if (nib <= 4'd9)
                res = {1'b0, nib + 4'd3};
        end else begin
            if (nib >= 4'd3 && nib <= 4'd12)
                res = {1'b0, nib - 4'd3};
        end
        return res;
    endfunction

    always_comb begin
        cur_nib = din_q[3:0];
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k))
                cur_nib = din_q[4*k +: 4];
        end
        conv_res = conv_digit(cur_nib, mode_q);
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        idx_d   = idx_q;
        din_d   = din_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    din_d   = din;
                    mode_d  = mode;
                    dout_d  = '0;
                    err_d   = '0;
                    idx_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        dout_d[4*k +: 4] = conv_res[3:0];
                        err_d[k]         = conv_res[4];
                    end
                end
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            din_q   <= '0;
            mode_q  <= 1'b0;
            dout_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // Handshake flags are decoded from the state register only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dout      = dout_q;
    assign err_mask  = err_q;

endmodule

// File: tb/tb_bcd_xs3_seq_converter.sv
// Self-checking bench for bcd_xs3_seq_converter: directed cases, a legal-code
// round-trip sweep and random words checked against a digit-wise arithmetic model.
module tb_bcd_xs3_seq_converter;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              mode;
    logic [W-1:0]      din;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      dout;
    logic [DIGITS-1:0] err_mask;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    bcd_xs3_seq_converter #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .err_mask  (err_mask),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each decimal digit handled independently with integer arithmetic.
    function automatic void ref_model(input logic [W-1:0] w, input logic m,
                                      output logic [W-1:0] r, output logic [DIGITS-1:0] e);
        int d;
        int o;
        bit bad;
        r = '0;
        e = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d = int'(w[4*k +: 4]);
            if (!m) begin
                bad = (d > 9);
                o   = d + 3;
            end else begin
                bad = (d < 3) || (d > 12);
                o   = d - 3;
            end
            if (bad) o = 15;
            r[4*k +: 4] = 4'(o);
            e[k]        = bad;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    // Sends one word; holds out_ready low for stall_cycles in DONE (pulsing in_valid meanwhile).
    task automatic send(input string tag, input logic [W-1:0] w, input logic m,
                        input int stall_cycles);
        logic [W-1:0]      exp_d;
        logic [DIGITS-1:0] exp_e;
        ref_model(w, m, exp_d, exp_e);
        wait_ready();
        in_valid  = 1'b1;
        din       = w;
        mode      = m;
        out_ready = (stall_cycles == 0);
        step();
        in_valid = 1'b0;
        din      = W'($urandom);
        mode     = 1'($urandom);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready_conv"}, in_ready, 0);
        check({tag, "_ov_e0"}, out_valid, 0);
        for (int c = 1; c < DIGITS; c++) begin
            step();
            check({tag, "_ov_conv"}, out_valid, 0);
        end
        step();
        check({tag, "_ov_done"}, out_valid, 1);
        check({tag, "_dout"}, dout, exp_d);
        check({tag, "_err"}, err_mask, exp_e);
        for (int s = 0; s < stall_cycles; s++) begin
            in_valid = (s == 2);
            din      = W'($urandom);
            step();
            check({tag, "_stall_ov"}, out_valid, 1);
            check({tag, "_stall_dout"}, dout, exp_d);
            check({tag, "_stall_err"}, err_mask, exp_e);
            check({tag, "_stall_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check({tag, "_ov_after"}, out_valid, 0);
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        logic [W-1:0]      fwd;
        logic [DIGITS-1:0] fe;
        logic [W-1:0]      w;

        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 0);
        check("rst_err", err_mask, 0);

        // Directed values cross-checked against hand-computed constants too.
        ref_model(16'h1995, 1'b0, fwd, fe);
        check("model_fwd", fwd, 16'h4CC8);
        send("fwd_1995", 16'h1995, 1'b0, 0);
        send("rev_4cc8", 16'h4CC8, 1'b1, 0);
        send("ill_fwd", 16'h12A9, 1'b0, 0);
        ref_model(16'h12A9, 1'b0, fwd, fe);
        check("model_ill_fwd", {fe, fwd}, {4'b0010, 16'h45FC});
        send("ill_rev", 16'h3302, 1'b1, 0);
        ref_model(16'h3302, 1'b1, fwd, fe);
        check("model_ill_rev", {fe, fwd}, {4'b0011, 16'h00FF});

        // Every legal digit, both directions, in every position.
        for (int v = 0; v < 10; v++) begin
            w = '0;
            for (int k = 0; k < DIGITS; k++) w[4*k +: 4] = 4'((v + k) % 10);
            ref_model(w, 1'b0, fwd, fe);
            send("sweep_fwd", w, 1'b0, 0);
            send("sweep_rev", fwd, 1'b1, 0);
            ref_model(fwd, 1'b1, fwd, fe);
            check("roundtrip", {fe, fwd}, {4'b0000, w});
        end

        send("stall", 16'h0937, 1'b0, 5);

        // Reset during the second CONV cycle discards the word.
        wait_ready();
        in_valid = 1'b1;
        din      = 16'h5678;
        mode     = 1'b0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_ov", out_valid, 0);
        check("midrst_dout", dout, 0);
        check("midrst_err", err_mask, 0);
        for (int c = 0; c < 8; c++) begin
            step();
            check("midrst_no_ov", out_valid, 0);
        end
        send("after_rst", 16'h5678, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            send("rand", W'($urandom), 1'($urandom), (i % 7 == 3) ? 2 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
